intersection_ctrl: RTL and testbench

Four-way intersection scheduler that sequences two opposing light groups, north-south (NS) and east-west (EW), through green, yellow and all-red clearance. It owns the single shared interval-timer interface (`t_start` / `t_length` / `t_flicker` / `t_done`) and guarantees the two directions are never both non-red. An optional pedestrian phase can be inserted between direction changes. It sits between the existing interval timer and the two lamp-driver outputs, replacing per-direction light FSMs.

---
 rtl/intersection_ctrl_if.sv | 21 ++
 rtl/intersection_ctrl.sv | 142 ++++++++++++++
 tb/tb_intersection_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_ctrl_if.sv
// Interval-timer link between intersection_ctrl (master) and the shared timer (slave).
interface intersection_ctrl_if;
  logic       t_start;
  logic [4:0] t_length;
  logic       t_flicker;
  logic       t_done;

  modport master (
    output t_start,
    output t_length,
    input  t_flicker,
    input  t_done
  );

  modport slave (
    input  t_start,
    input  t_length,
    output t_flicker,
    output t_done
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Four-way intersection scheduler: sequences NS and EW lamps through green, yellow and
// all-red clearance on the shared interval timer, with an optional pedestrian phase.
// Optional feature macro: PED_REQ_EN (pedestrian request / PED state).
module intersection_ctrl #(
  parameter logic [4:0] GREEN_DURATION  = 5'd30,
  parameter logic [4:0] YELLOW_DURATION = 5'd3,
  parameter logic [4:0] ALLRED_DURATION = 5'd2,
  parameter logic [4:0] PED_DURATION    = 5'd10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ped_req,
  intersection_ctrl_if.master        tmr,
  output logic [1:0]                 L_ns,
  output logic [1:0]                 L_ew,
  output logic                       ped_walk
);

  localparam logic [1:0] LampOff    = 2'b00;
  localparam logic [1:0] LampRed    = 2'b01;
  localparam logic [1:0] LampYellow = 2'b10;
  localparam logic [1:0] LampGreen  = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StNsGreen, StNsYellow, StNsClear, StEwGreen, StEwYellow, StEwClear, StPed
  } state_e;

  state_e     state_q, state_d;
  logic       t_start_q;
  logic [4:0] t_length_q, t_length_d;
  logic [1:0] lamp_ns_q, lamp_ns_d, lamp_ew_q, lamp_ew_d;
  logic       ped_walk_q, ped_walk_d;
  logic       advance;
  logic       ped_pending;
  logic       next_dir;  // 1: resume EW after PED, 0: resume NS

  // Next-state: every timed state advances on t_done, except in its stale first cycle.
  always_comb begin
    state_d = state_q;
    advance = tmr.t_done && !t_start_q;
    case (state_q)
      StIdle:     if (start)   state_d = StNsGreen;
      StNsGreen:  if (advance) state_d = StNsYellow;
      StNsYellow: if (advance) state_d = StNsClear;
      StNsClear:  if (advance) state_d = ped_pending ? StPed : StEwGreen;
      StEwGreen:  if (advance) state_d = StEwYellow;
      StEwYellow: if (advance) state_d = StEwClear;
      StEwClear:  if (advance) state_d = ped_pending ? StPed : StNsGreen;
      StPed:      if (advance) state_d = next_dir ? StEwGreen : StNsGreen;
      default:    state_d = StIdle;
    endcase
  end

  // Decode the upcoming state so lamps, length and walk are registered with the state.
  always_comb begin
    lamp_ns_d  = LampOff;
    lamp_ew_d  = LampOff;
    t_length_d = 5'd0;
    ped_walk_d = 1'b0;
    case (state_d)
      StNsGreen:  begin lamp_ns_d = LampGreen;  lamp_ew_d = LampRed; t_length_d = GREEN_DURATION;  end
      StNsYellow: begin lamp_ns_d = LampYellow; lamp_ew_d = LampRed; t_length_d = YELLOW_DURATION; end
      StNsClear:  begin lamp_ns_d = LampRed;    lamp_ew_d = LampRed; t_length_d = ALLRED_DURATION; end
      StEwGreen:  begin lamp_ns_d = LampRed; lamp_ew_d = LampGreen;  t_length_d = GREEN_DURATION;  end
      StEwYellow: begin lamp_ns_d = LampRed; lamp_ew_d = LampYellow; t_length_d = YELLOW_DURATION; end
      StEwClear:  begin lamp_ns_d = LampRed; lamp_ew_d = LampRed;    t_length_d = ALLRED_DURATION; end
      StPed: begin
        lamp_ns_d  = LampRed;
        lamp_ew_d  = LampRed;
        t_length_d = PED_DURATION;
        ped_walk_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered outputs; t_start marks the first cycle of each timed state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      t_start_q  <= 1'b0;
      t_length_q <= 5'd0;
      lamp_ns_q  <= LampOff;
      lamp_ew_q  <= LampOff;
      ped_walk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_start_q  <= (state_d != state_q) && (state_d != StIdle);
      t_length_q <= t_length_d;
      lamp_ns_q  <= lamp_ns_d;
      lamp_ew_q  <= lamp_ew_d;
      ped_walk_q <= ped_walk_d;
    end
  end

`ifdef PED_REQ_EN
  logic ped_pending_q, next_dir_q;
  logic enter_ped;

  assign enter_ped = (state_d == StPed) && (state_q != StPed);

  // Pending request and resume direction; entering PED absorbs a same-cycle request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
      next_dir_q    <= 1'b0;
    end else begin
      if (enter_ped) begin
        ped_pending_q <= 1'b0;
        next_dir_q    <= (state_q == StNsClear);
      end else if (ped_req && (state_q != StIdle)) begin
        ped_pending_q <= 1'b1;
      end
    end
  end

  assign ped_pending = ped_pending_q;
  assign next_dir    = next_dir_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
  assign next_dir       = 1'b0;
`endif

  // Flicker blanks the active green lamp with no added latency.
  always_comb begin
    L_ns = lamp_ns_q;
    L_ew = lamp_ew_q;
    if (tmr.t_flicker) begin
      if (state_q == StNsGreen) L_ns = LampOff;
      if (state_q == StEwGreen) L_ew = LampOff;
    end
  end

  assign tmr.t_start  = t_start_q;
  assign tmr.t_length = t_length_q;
  assign ped_walk     = ped_walk_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: ring-table model plus directed literal checks.
module tb_intersection_ctrl;

`ifdef PED_REQ_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif
  localparam int PedPos = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] L_ns, L_ew;
  logic       ped_walk;

  intersection_ctrl_if tif ();

  intersection_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ped_req  (ped_req),
    .tmr      (tif.master),
    .L_ns     (L_ns),
    .L_ew     (L_ew),
    .ped_walk (ped_walk)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the ring NSG,NSY,NSC,EWG,EWY,EWC (0..5), PedPos, or -1 for idle.
  int ns_tab[6]  = '{3, 2, 1, 1, 1, 1};
  int ew_tab[6]  = '{1, 1, 1, 3, 2, 1};
  int len_tab[6] = '{30, 3, 2, 30, 3, 2};

  int m_pos = -1;
  bit m_fresh = 1'b0;
  bit m_pend = 1'b0;
  int m_resume = 0;
  int m_nxt, m_res_nxt;
  bit m_pend_nxt;

  // Model next-step from the behavioural rules.
  always_comb begin
    m_nxt      = m_pos;
    m_res_nxt  = m_resume;
    m_pend_nxt = m_pend;
    if (m_pos < 0) begin
      if (start) m_nxt = 0;
    end else if (tif.t_done && !m_fresh) begin
      if (m_pos == PedPos) m_nxt = m_resume;
      else if (PedEn && m_pend && (m_pos % 3 == 2)) begin
        m_nxt     = PedPos;
        m_res_nxt = (m_pos + 1) % 6;
      end else m_nxt = (m_pos + 1) % 6;
    end
    if (m_nxt == PedPos && m_pos != PedPos) m_pend_nxt = 1'b0;
    else if (PedEn && m_pos >= 0 && ped_req) m_pend_nxt = 1'b1;
  end

  // Model register.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos    <= -1;
      m_fresh  <= 1'b0;
      m_pend   <= 1'b0;
      m_resume <= 0;
    end else begin
      m_fresh  <= (m_nxt != m_pos);
      m_pos    <= m_nxt;
      m_pend   <= m_pend_nxt;
      m_resume <= m_res_nxt;
    end
  end

  // Compare DUT with model every cycle, away from the active edge.
  always @(negedge clk) begin
    int e_ns, e_ew, e_len, e_walk;
    e_ns = 0; e_ew = 0; e_len = 0; e_walk = 0;
    if (m_pos == PedPos) begin
      e_ns = 1; e_ew = 1; e_len = 10; e_walk = 1;
    end else if (m_pos >= 0) begin
      e_ns  = ns_tab[m_pos];
      e_ew  = ew_tab[m_pos];
      e_len = len_tab[m_pos];
      if (tif.t_flicker && m_pos == 0) e_ns = 0;
      if (tif.t_flicker && m_pos == 3) e_ew = 0;
    end
    check("m_L_ns", int'(L_ns), e_ns);
    check("m_L_ew", int'(L_ew), e_ew);
    check("m_t_length", int'(tif.t_length), e_len);
    check("m_ped_walk", int'(ped_walk), e_walk);
    check("m_t_start", int'(tif.t_start), int'(m_fresh && m_pos >= 0));
    if (m_pos >= 0) check("m_safe", int'(L_ns == 2'b01 || L_ew == 2'b01), 1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tif.t_done = 1'b1;
    cyc();
    tif.t_done = 1'b0;
  endtask

  task automatic advance();
    cyc();
    pulse_done();
  endtask

  initial begin
    tif.t_done    = 1'b0;
    tif.t_flicker = 1'b0;
    cyc();
    cyc();
    check("rst_L_ns", int'(L_ns), 0);
    check("rst_L_ew", int'(L_ew), 0);
    check("rst_t_start", int'(tif.t_start), 0);
    check("rst_t_length", int'(tif.t_length), 0);
    check("rst_ped_walk", int'(ped_walk), 0);
    reset = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("nsg_t_start", int'(tif.t_start), 1);
    check("nsg_t_length", int'(tif.t_length), 30);
    check("nsg_L_ns", int'(L_ns), 3);
    check("nsg_L_ew", int'(L_ew), 1);
    cyc();
    check("nsg_t_start_low", int'(tif.t_start), 0);
    pulse_done();
    check("nsy_L_ns", int'(L_ns), 2);
    check("nsy_t_length", int'(tif.t_length), 3);
    // t_done in the first cycle of NS_YELLOW is stale and must be ignored
    pulse_done();
    check("stale_L_ns", int'(L_ns), 2);
    check("stale_t_start", int'(tif.t_start), 0);
    pulse_done();
    check("nsc_L_ns", int'(L_ns), 1);
    check("nsc_t_length", int'(tif.t_length), 2);
    tif.t_flicker = 1'b1;
    cyc();
    tif.t_flicker = 1'b0;
    pulse_done();
    check("ewg_L_ew", int'(L_ew), 3);
    check("ewg_t_length", int'(tif.t_length), 30);
    cyc();
    tif.t_flicker = 1'b1;
    #1;
    check("flk1_L_ew", int'(L_ew), 0);
    check("flk1_L_ns", int'(L_ns), 1);
    cyc();
    check("flk2_L_ew", int'(L_ew), 0);
    tif.t_flicker = 1'b0;
    #1;
    check("flk_end_L_ew", int'(L_ew), 3);
    pulse_done();
    check("ewy_L_ew", int'(L_ew), 2);
    advance();
    check("ewc_t_length", int'(tif.t_length), 2);
    advance();
    check("nsg2_L_ns", int'(L_ns), 3);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    pulse_done();
    advance();
    advance();
`ifdef PED_REQ_EN
    check("ped_walk_on", int'(ped_walk), 1);
    check("ped_t_length", int'(tif.t_length), 10);
    check("ped_t_start", int'(tif.t_start), 1);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    pulse_done();
    check("ped_exit_walk", int'(ped_walk), 0);
    check("ped_exit_L_ew", int'(L_ew), 3);
    advance();
    advance();
    cyc();
    tif.t_done = 1'b1;
    ped_req    = 1'b1;
    cyc();
    tif.t_done = 1'b0;
    ped_req    = 1'b0;
    check("ped2_walk", int'(ped_walk), 1);
    advance();
    check("ped2_resume_L_ns", int'(L_ns), 3);
    check("ped2_resume_walk", int'(ped_walk), 0);
    advance();
    advance();
    advance();
    check("absorbed_L_ew", int'(L_ew), 3);
    check("absorbed_walk", int'(ped_walk), 0);
`else
    check("noped_walk", int'(ped_walk), 0);
    check("noped_t_length", int'(tif.t_length), 30);
    check("noped_L_ew", int'(L_ew), 3);
`endif
    advance();
    check("ewy2_L_ew", int'(L_ew), 2);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check("arst_L_ns", int'(L_ns), 0);
    check("arst_L_ew", int'(L_ew), 0);
    check("arst_t_start", int'(tif.t_start), 0);
    check("arst_t_length", int'(tif.t_length), 0);
    check("arst_ped_walk", int'(ped_walk), 0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    check("idle_L_ns", int'(L_ns), 0);
    check("idle_t_length", int'(tif.t_length), 0);
    cyc();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
